// File: rtl/audio_addr_sequencer.sv
// Flash-sample address sequencer: walks [start_addr, end_addr] forward or reverse, fetches each
// word over req/ack and emits one SAMPLE_W slice per sample_tick. AUDIO_ADDR_SEQ_UNDERRUN_CNT_EN
// enables the dropped-tick counter.
module audio_addr_sequencer #(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                play,
    input  logic                dir,
    input  logic                loop,
    input  logic                restart,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                sample_tick,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_ack,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [ADDR_W-1:0]   addr,
    output logic                done,
    output logic [15:0]         underrun_cnt
);
    localparam int unsigned N     = DATA_W / SAMPLE_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_req_q, rd_req_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                discard_q, discard_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                done_q, done_d;

    logic [SAMPLE_W-1:0] slices [N];
    logic [ADDR_W-1:0]   head_addr, step_addr;
    logic [IDX_W-1:0]    head_idx;
    logic                last_slice, range_end;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            slices[i] = word_q[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Head and step use the live dir input: it is only consulted at restart and word boundaries.
    assign head_addr  = dir ? end_addr : start_addr;
    assign head_idx   = dir ? IDX_LAST : '0;
    assign step_addr  = dir ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    assign last_slice = dir_q ? (idx_q == '0) : (idx_q == IDX_LAST);
    assign range_end  = dir_q ? (addr_q == start_addr) : (addr_q == end_addr);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rd_addr_d      = rd_addr_q;
        rd_req_d       = rd_req_q;
        idx_d          = idx_q;
        dir_d          = dir_q;
        word_d         = word_q;
        discard_d      = discard_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = done_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (restart) begin
                    state_d   = StFetch;
                    addr_d    = head_addr;
                    idx_d     = head_idx;
                    dir_d     = dir;
                    done_d    = 1'b0;
                    rd_req_d  = 1'b1;
                    rd_addr_d = head_addr;
                end
            end
            StFetch: begin
                if (restart) begin
                    addr_d = head_addr;
                    idx_d  = head_idx;
                    dir_d  = dir;
                    done_d = 1'b0;
                end
                if (rd_req_q) begin
                    if (rd_ack) begin
                        rd_req_d  = 1'b0;
                        discard_d = 1'b0;
                        // Data for a request issued before a restart is dropped; the
                        // request-free cycle below then re-issues at the new head.
                        if (!(discard_q || restart)) begin
                            word_d  = rd_data;
                            state_d = StPlay;
                        end
                    end else if (restart) begin
                        discard_d = 1'b1;
                    end
                end else begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_d;
                end
            end
            StPlay: begin
                if (restart) begin
                    state_d   = StFetch;
                    addr_d    = head_addr;
                    idx_d     = head_idx;
                    dir_d     = dir;
                    done_d    = 1'b0;
                    rd_req_d  = 1'b1;
                    rd_addr_d = head_addr;
                end else if (play && sample_tick) begin
                    sample_d       = slices[idx_q];
                    sample_valid_d = 1'b1;
                    if (!last_slice) begin
                        idx_d = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
                    end else begin
                        dir_d = dir;
                        idx_d = head_idx;
                        if (range_end && !loop) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = StFetch;
                            addr_d    = range_end ? head_addr : step_addr;
                            rd_req_d  = 1'b1;
                            rd_addr_d = range_end ? head_addr : step_addr;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            rd_addr_q      <= '0;
            rd_req_q       <= 1'b0;
            idx_q          <= '0;
            dir_q          <= 1'b0;
            word_q         <= '0;
            discard_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rd_addr_q      <= rd_addr_d;
            rd_req_q       <= rd_req_d;
            idx_q          <= idx_d;
            dir_q          <= dir_d;
            word_q         <= word_d;
            discard_q      <= discard_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
        end
    end

`ifdef AUDIO_ADDR_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    logic        drop_tick;

    assign drop_tick = (state_q == StFetch) && play && sample_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= '0;
        end else if (drop_tick && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

    assign addr         = addr_q;
    assign rd_addr      = rd_addr_q;
    assign rd_req       = rd_req_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;
endmodule

// File: tb/tb_audio_addr_sequencer.sv
// Randomised bench for audio_addr_sequencer: flash reader model with configurable ack latency,
// tick generator, and an address/sample-order reference model derived from the range rules.
module tb_audio_addr_sequencer;
    localparam int AW = 23;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            play = 1'b0;
    logic            dir = 1'b0;
    logic            loop = 1'b0;
    logic            restart = 1'b0;
    logic [AW-1:0]   start_addr = '0;
    logic [AW-1:0]   end_addr = '0;
    logic            sample_tick = 1'b0;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_ack = 1'b0;
    logic [31:0]     rd_data = '0;
    logic [15:0]     sample;
    logic            sample_valid;
    logic [AW-1:0]   addr;
    logic            done;
    logic [15:0]     underrun_cnt;

    int              checks = 0;
    int              failures = 0;
    logic [31:0]     seed = 32'h0;
    int              ack_lat = 2;
    int              tick_period = 8;
    bit              tick_en = 1'b0;
    logic [AW-1:0]   got_reads[$];
    logic [15:0]     got_samples[$];
    int              ticks_seen = 0;
    int              rbase = 0;
    int              sbase = 0;
    int              tbase = 0;
    logic [AW-1:0]   exp_reads[$];
    logic [15:0]     exp_samples[$];

    audio_addr_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .play         (play),
        .dir          (dir),
        .loop         (loop),
        .restart      (restart),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .sample_tick  (sample_tick),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .addr         (addr),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return ({9'b0, a} * 32'h9E37_79B1) ^ seed;
    endfunction

    // Flash reader: latches the address of a new request, acks ack_lat cycles later.
    initial begin : flash_model
        int            remaining;
        logic [AW-1:0] lat_addr;
        remaining = -1;
        lat_addr  = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                remaining = -1;
                rd_ack    = 1'b0;
            end else begin
                #1;
                rd_ack = 1'b0;
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) begin
                        rd_ack    = 1'b1;
                        rd_data   = word_of(lat_addr);
                        remaining = -1;
                    end
                end else if (rd_req) begin
                    remaining = ack_lat;
                    lat_addr  = rd_addr;
                end
            end
        end
    end

    initial begin : ticker
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                sample_tick = (ph == 0);
                ph = (ph >= tick_period - 1) ? 0 : ph + 1;
            end else begin
                sample_tick = 1'b0;
                ph = 0;
            end
        end
    end

    initial begin : monitor
        bit prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (sample_valid) got_samples.push_back(sample);
            if (rd_req && !prev_req) got_reads.push_back(rd_addr);
            if (sample_tick && play) ticks_seen++;
            prev_req = rd_req;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        rbase = got_reads.size();
        sbase = got_samples.size();
        tbase = ticks_seen;
    endtask

    task automatic do_reset();
        tick_en = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);
        mark();
    endtask

    task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic d,
                        input logic lp);
        start_addr = s;
        end_addr   = e;
        dir        = d;
        loop       = lp;
        play       = 1'b1;
        restart    = 1'b1;
        step(1);
        restart    = 1'b0;
        mark();
        tick_en    = 1'b1;
    endtask

    task automatic wait_samples(input int n, input int budget, input string name);
        int c;
        c = 0;
        while ((got_samples.size() - sbase) < n && c < budget) begin
            step(1);
            c++;
        end
        if ((got_samples.size() - sbase) < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: samples=%0d required=%0d", name,
                     got_samples.size() - sbase, n);
        end
    endtask

    // Reference: walk the range by the playback rules, listing word reads and sample order.
    task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic d,
                         input logic lp, input int nsamp);
        logic [AW-1:0] a;
        logic [31:0]   w;
        exp_reads.delete();
        exp_samples.delete();
        a = d ? e : s;
        while (exp_samples.size() < nsamp) begin
            exp_reads.push_back(a);
            w = word_of(a);
            if (d) begin
                exp_samples.push_back(w[31:16]);
                exp_samples.push_back(w[15:0]);
            end else begin
                exp_samples.push_back(w[15:0]);
                exp_samples.push_back(w[31:16]);
            end
            if (a == (d ? s : e)) begin
                if (!lp) break;
                a = d ? e : s;
            end else begin
                a = d ? a - 23'd1 : a + 23'd1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
        if (rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr); end
        if (addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
        if (sample !== '0) begin failures++; $display("FAIL reset_sample got=%h exp=0", sample); end
        if (sample_valid !== 1'b0) begin
            failures++; $display("FAIL reset_sample_valid got=%b exp=0", sample_valid);
        end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (underrun_cnt !== '0) begin
            failures++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt);
        end
    endtask

    task automatic test_forward_loop();
        logic [AW-1:0] g;
        logic [15:0]   gs;
        do_reset();
        ack_lat = 2;
        tick_period = 8;
        kick(23'd59072, 23'd59074, 1'b0, 1'b1);
        wait_samples(8, 600, "fwd_loop");
        tick_en = 1'b0;
        step(4);
        model(23'd59072, 23'd59074, 1'b0, 1'b1, 8);
        for (int i = 0; i < 4; i++) begin
            g = (rbase + i < got_reads.size()) ? got_reads[rbase + i] : 'x;
            checks++;
            if (g !== exp_reads[i]) begin
                failures++; $display("FAIL fwd_read[%0d] got=%0d exp=%0d", i, g, exp_reads[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            gs = (sbase + i < got_samples.size()) ? got_samples[sbase + i] : 'x;
            checks++;
            if (gs !== exp_samples[i]) begin
                failures++; $display("FAIL fwd_sample[%0d] got=%h exp=%h", i, gs, exp_samples[i]);
            end
        end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL fwd_done got=%b exp=0", done); end
    endtask

    task automatic test_reverse_oneshot();
        int c;
        logic [15:0] gs;
        do_reset();
        ack_lat = 2;
        tick_period = 8;
        kick(23'd59072, 23'd59074, 1'b1, 1'b0);
        c = 0;
        while (!done && c < 600) begin step(1); c++; end
        step(40);
        tick_en = 1'b0;
        step(2);
        model(23'd59072, 23'd59074, 1'b1, 1'b0, 6);
        checks += 4;
        if (got_samples.size() - sbase != 6) begin
            failures++; $display("FAIL rev_sample_count got=%0d exp=6", got_samples.size() - sbase);
        end
        if (got_reads.size() - rbase != 3) begin
            failures++; $display("FAIL rev_read_count got=%0d exp=3", got_reads.size() - rbase);
        end
        if (done !== 1'b1) begin failures++; $display("FAIL rev_done got=%b exp=1", done); end
        if (rd_req !== 1'b0) begin failures++; $display("FAIL rev_rd_req got=%b exp=0", rd_req); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rbase + i >= got_reads.size() || got_reads[rbase + i] !== exp_reads[i]) begin
                failures++; $display("FAIL rev_read[%0d] exp=%0d", i, exp_reads[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            gs = (sbase + i < got_samples.size()) ? got_samples[sbase + i] : 'x;
            checks++;
            if (gs !== exp_samples[i]) begin
                failures++; $display("FAIL rev_sample[%0d] got=%h exp=%h", i, gs, exp_samples[i]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [AW-1:0] s, e;
        logic [15:0]   gs, exp_u;
        int            n;
        do_reset();
        ack_lat = 10;
        tick_period = 4;
        s = AW'($urandom);
        e = s + AW'($urandom_range(1, 3));
        kick(s, e, 1'b0, 1'b1);
        wait_samples(10, 1500, "underrun");
        tick_en = 1'b0;
        step(15);
        n = got_samples.size() - sbase;
        model(s, e, 1'b0, 1'b1, n);
`ifdef AUDIO_ADDR_SEQ_UNDERRUN_CNT_EN
        exp_u = 16'(ticks_seen - tbase - n);
`else
        exp_u = 16'd0;
`endif
        checks++;
        if (underrun_cnt !== exp_u) begin
            failures++; $display("FAIL underrun_cnt got=%0d exp=%0d", underrun_cnt, exp_u);
        end
        for (int i = 0; i < n; i++) begin
            gs = got_samples[sbase + i];
            checks++;
            if (gs !== exp_samples[i]) begin
                failures++; $display("FAIL underrun_sample[%0d] got=%h exp=%h", i, gs, exp_samples[i]);
            end
        end
    endtask

    task automatic test_restart_mid_fetch();
        int          c;
        bit          held;
        logic [31:0] w;
        do_reset();
        ack_lat = 6;
        tick_period = 8;
        kick(23'd59072, 23'd59074, 1'b0, 1'b1);
        c = 0;
        while ((got_reads.size() - rbase) < 2 && c < 400) begin step(1); c++; end
        checks++;
        if ((got_reads.size() - rbase) < 2 || got_reads[rbase + 1] !== 23'd59073) begin
            failures++; $display("FAIL restart_pre_read got_count=%0d exp_addr=59073",
                                 got_reads.size() - rbase);
        end
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        mark();
        held = 1'b1;
        c = 0;
        while (!rd_ack && c < 20) begin
            @(negedge clk);
            if (!rd_req) held = 1'b0;
            c++;
        end
        checks += 2;
        if (!held) begin failures++; $display("FAIL restart_req_held got=0 exp=1"); end
        if (c >= 20) begin failures++; $display("FAIL restart_ack timeout got=none exp=ack"); end
        wait_samples(1, 300, "restart");
        w = word_of(23'd59072);
        checks += 2;
        if (got_reads.size() <= rbase || got_reads[rbase] !== 23'd59072) begin
            failures++; $display("FAIL restart_reissue_addr exp=59072 count=%0d",
                                 got_reads.size() - rbase);
        end
        if (got_samples.size() <= sbase || got_samples[sbase] !== w[15:0]) begin
            failures++; $display("FAIL restart_first_sample exp=%h", w[15:0]);
        end
        tick_en = 1'b0;
        step(2);
    endtask

    task automatic test_pause();
        int          n0;
        logic [15:0] exp_u, gs;
        do_reset();
        ack_lat = 2;
        tick_period = 8;
        kick(23'd59072, 23'd59074, 1'b0, 1'b1);
        wait_samples(1, 300, "pause_pre");
        play = 1'b0;
        n0 = got_samples.size();
        step(50);
`ifdef AUDIO_ADDR_SEQ_UNDERRUN_CNT_EN
        exp_u = 16'(ticks_seen - tbase - (got_samples.size() - sbase));
`else
        exp_u = 16'd0;
`endif
        checks += 2;
        if (got_samples.size() != n0) begin
            failures++; $display("FAIL pause_samples got=%0d exp=%0d", got_samples.size(), n0);
        end
        if (underrun_cnt !== exp_u) begin
            failures++; $display("FAIL pause_underrun got=%0d exp=%0d", underrun_cnt, exp_u);
        end
        play = 1'b1;
        wait_samples(3, 300, "pause_post");
        tick_en = 1'b0;
        step(4);
        model(23'd59072, 23'd59074, 1'b0, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            gs = (sbase + i < got_samples.size()) ? got_samples[sbase + i] : 'x;
            checks++;
            if (gs !== exp_samples[i]) begin
                failures++; $display("FAIL pause_sample[%0d] got=%h exp=%h", i, gs, exp_samples[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        ack_lat = 8;
        tick_period = 4;
        kick(23'd59072, 23'd59074, 1'b0, 1'b1);
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks += 6;
        if (rd_req !== 1'b0) begin failures++; $display("FAIL arst_rd_req got=%b exp=0", rd_req); end
        if (rd_addr !== '0) begin failures++; $display("FAIL arst_rd_addr got=%h exp=0", rd_addr); end
        if (addr !== '0) begin failures++; $display("FAIL arst_addr got=%h exp=0", addr); end
        if (sample_valid !== 1'b0) begin
            failures++; $display("FAIL arst_sample_valid got=%b exp=0", sample_valid);
        end
        if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
        if (underrun_cnt !== '0) begin
            failures++; $display("FAIL arst_underrun got=%0d exp=0", underrun_cnt);
        end
        step(3);
        reset_n = 1'b1;
        mark();
        step(40);
        checks += 2;
        if (got_reads.size() != rbase) begin
            failures++; $display("FAIL arst_no_fetch got=%0d exp=0", got_reads.size() - rbase);
        end
        if (got_samples.size() != sbase) begin
            failures++; $display("FAIL arst_no_sample got=%0d exp=0", got_samples.size() - sbase);
        end
        tick_en = 1'b0;
    endtask

    task automatic test_random_ranges();
        logic [AW-1:0] s, e, diff;
        logic          d, lp;
        logic [15:0]   gs;
        int            need, c;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            if (it == 0) begin
                s = 23'h7FFFFF; e = 23'd1; d = 1'b0; lp = 1'b0;
            end else begin
                s = AW'($urandom);
                e = s + AW'($urandom_range(0, 2));
                d = 1'($urandom);
                lp = 1'($urandom);
            end
            ack_lat = $urandom_range(1, 5);
            tick_period = $urandom_range(3, 10);
            diff = e - s;
            need = lp ? 2 * (int'(diff) + 1) + 2 : 2 * (int'(diff) + 1);
            kick(s, e, d, lp);
            if (lp) begin
                wait_samples(need, 2000, "rand_loop");
            end else begin
                c = 0;
                while (!done && c < 2000) begin step(1); c++; end
                step(20);
            end
            tick_en = 1'b0;
            step(15);
            model(s, e, d, lp, need);
            checks++;
            if (done !== !lp) begin failures++; $display("FAIL rand%0d_done got=%b exp=%b", it, done, !lp); end
            if (!lp) begin
                checks++;
                if (got_samples.size() - sbase != need) begin
                    failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it,
                                         got_samples.size() - sbase, need);
                end
            end
            for (int i = 0; i < need; i++) begin
                gs = (sbase + i < got_samples.size()) ? got_samples[sbase + i] : 'x;
                checks++;
                if (gs !== exp_samples[i]) begin
                    failures++; $display("FAIL rand%0d_sample[%0d] got=%h exp=%h", it, i, gs,
                                         exp_samples[i]);
                end
            end
            for (int i = 0; i < exp_reads.size(); i++) begin
                checks++;
                if (rbase + i >= got_reads.size() || got_reads[rbase + i] !== exp_reads[i]) begin
                    failures++; $display("FAIL rand%0d_read[%0d] exp=%h", it, i, exp_reads[i]);
                end
            end
        end
    endtask

    initial begin : main
        seed = $urandom;
        test_reset();
        test_forward_loop();
        test_reverse_oneshot();
        test_underrun();
        test_restart_mid_fetch();
        test_pause();
        test_reset_mid_fetch();
        test_random_ranges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
